// File: rtl/order_stream_gen.sv
// N_CH-channel LFSR price generator: one buy/sell set per tick, independent or bounded random-walk mode.
// A tick arriving while the previous set is still unaccepted is dropped and counted; outputs hold stable.
module order_stream_gen #(
   parameter int          N_CH       = 4,
   parameter int          PRICE_W    = 8,
   parameter int          SPAN_W     = 5,
   parameter int          BASE       = 50,
   parameter int          MIN_SPREAD = 1,
   parameter int          TICK_DIV   = 2**25,
   parameter int          WALK_MIN   = 40,
   parameter int          WALK_MAX   = 80,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    mode,
   input  logic                    seed_req,
   output logic [N_CH*PRICE_W-1:0] buy_price,
   output logic [N_CH*PRICE_W-1:0] sell_price,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    tick,
   output logic [7:0]              drop_cnt
);
   localparam int                   DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam int                   SW        = PRICE_W + 2;
   localparam logic [PRICE_W-1:0]   PRICE_MAX = '1;
   localparam logic signed [SW-1:0] WMIN_S    = SW'(WALK_MIN);
   localparam logic signed [SW-1:0] WMAX_S    = SW'(WALK_MAX);

   logic [DIV_W-1:0] div;
   logic [15:0]      cyc_cnt;
   logic             seed_s1, seed_s2, seed_s3;
   logic             seed_rise;
   logic             mode_q;
   logic             load;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] nonzero(input logic [15:0] v);
      return (v == 16'd0) ? 16'h0001 : v;
   endfunction

   assign seed_rise = seed_s2 & ~seed_s3;
   // A new set is accepted into the output registers only when the slot is free or being emptied now.
   assign load      = tick & (~out_valid | out_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div       <= '0;
         cyc_cnt   <= 16'd0;
         tick      <= 1'b0;
         out_valid <= 1'b0;
         drop_cnt  <= 8'd0;
         mode_q    <= 1'b0;
         seed_s1   <= 1'b0;
         seed_s2   <= 1'b0;
         seed_s3   <= 1'b0;
      end else begin
         seed_s1 <= seed_req;
         seed_s2 <= seed_s1;
         seed_s3 <= seed_s2;
         cyc_cnt <= cyc_cnt + 16'd1;
         if (enable) begin
            tick <= (div == DIV_LAST);
            div  <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
         end else begin
            tick <= 1'b0;
         end
         if (tick) begin
            mode_q <= mode;
            if (load)
               out_valid <= 1'b1;
            else if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam logic [15:0] KEY      = 16'(c * 32'h1F35);
      localparam logic [15:0] RST_LFSR = ((SEED ^ KEY) == 16'd0) ? 16'h0001 : (SEED ^ KEY);

      logic [15:0]          lfsr, base, nxt;
      logic [PRICE_W-1:0]   buy_r, sell_r, mid_r;
      logic [PRICE_W-1:0]   mid_src, walk_mid, buy_nxt, sell_nxt;
      logic signed [SW-1:0] walk_raw, mag;
      logic [SW-1:0]        ind_sum, sell_sum;

      always_comb begin
         base     = seed_rise ? nonzero(lfsr ^ cyc_cnt ^ KEY) : lfsr;
         nxt      = lfsr_step(base);
         // Entering walk mode starts the walk from the price currently presented.
         mid_src  = (mode && !mode_q) ? buy_r : mid_r;
         mag      = SW'(nxt[2:1]);
         walk_raw = nxt[0] ? $signed({2'b00, mid_src}) + mag
                           : $signed({2'b00, mid_src}) - mag;
         if (walk_raw < WMIN_S)
            walk_mid = PRICE_W'(WALK_MIN);
         else if (walk_raw > WMAX_S)
            walk_mid = PRICE_W'(WALK_MAX);
         else
            walk_mid = walk_raw[PRICE_W-1:0];
         ind_sum  = SW'(BASE) + SW'(nxt[SPAN_W-1:0]);
         if (mode)
            buy_nxt = walk_mid;
         else
            buy_nxt = (ind_sum > SW'(PRICE_MAX)) ? PRICE_MAX : ind_sum[PRICE_W-1:0];
         sell_sum = SW'(buy_nxt) + SW'(MIN_SPREAD) + SW'(nxt[15 -: SPAN_W]);
         sell_nxt = (sell_sum > SW'(PRICE_MAX)) ? PRICE_MAX : sell_sum[PRICE_W-1:0];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            lfsr   <= RST_LFSR;
            buy_r  <= PRICE_W'(BASE);
            sell_r <= PRICE_W'(BASE + MIN_SPREAD);
            mid_r  <= PRICE_W'(BASE);
         end else begin
            lfsr <= tick ? nxt : base;
            if (tick && mode)
               mid_r <= walk_mid;
            if (load) begin
               buy_r  <= buy_nxt;
               sell_r <= sell_nxt;
            end
         end
      end

      assign buy_price[c*PRICE_W +: PRICE_W]  = buy_r;
      assign sell_price[c*PRICE_W +: PRICE_W] = sell_r;
   end

endmodule
